// File: rtl/three_function_barrel_shifter.sv
// 8-bit registered barrel shifter: store, rotate, logical shift and arithmetic shift.
// The shift is a three-stage log shifter (1, 2, 4 positions) feeding one output register.
module three_function_barrel_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [1:0] operation,
  input  logic [2:0] number_of_positions,
  input  logic       direction,
  output logic [7:0] out_data
);

  localparam logic [1:0] OP_STORE = 2'd0;
  localparam logic [1:0] OP_ROT   = 2'd1;
  localparam logic [1:0] OP_LSH   = 2'd2;
  localparam logic [1:0] OP_ASH   = 2'd3;

  // Fill bits for a 1-position stage; the sign comes from the original operand.
  function automatic logic [7:0] shift_by1(input logic [7:0] x, input logic en,
                                           input logic dir, input logic [1:0] op,
                                           input logic sign);
    logic fill;
    if (!en) return x;
    if (!dir) begin
      fill = (op == OP_ROT) ? x[7] : 1'b0;
      return {x[6:0], fill};
    end
    fill = (op == OP_ROT) ? x[0] : ((op == OP_ASH) ? sign : 1'b0);
    return {fill, x[7:1]};
  endfunction

  function automatic logic [7:0] shift_by2(input logic [7:0] x, input logic en,
                                           input logic dir, input logic [1:0] op,
                                           input logic sign);
    logic [1:0] fill;
    if (!en) return x;
    if (!dir) begin
      fill = (op == OP_ROT) ? x[7:6] : 2'b00;
      return {x[5:0], fill};
    end
    fill = (op == OP_ROT) ? x[1:0] : ((op == OP_ASH) ? {2{sign}} : 2'b00);
    return {fill, x[7:2]};
  endfunction

  function automatic logic [7:0] shift_by4(input logic [7:0] x, input logic en,
                                           input logic dir, input logic [1:0] op,
                                           input logic sign);
    logic [3:0] fill;
    if (!en) return x;
    if (!dir) begin
      fill = (op == OP_ROT) ? x[7:4] : 4'b0000;
      return {x[3:0], fill};
    end
    fill = (op == OP_ROT) ? x[3:0] : ((op == OP_ASH) ? {4{sign}} : 4'b0000);
    return {fill, x[7:4]};
  endfunction

  logic signed [7:0] operand;
  logic        [7:0] stage1;
  logic        [7:0] stage2;
  logic        [7:0] stage4;
  logic        [7:0] out_data_d;
  logic        [7:0] out_data_q;

  always_comb begin
    operand    = in_data;
    stage1     = shift_by1(operand, number_of_positions[0], direction, operation, operand[7]);
    stage2     = shift_by2(stage1, number_of_positions[1], direction, operation, operand[7]);
    stage4     = shift_by4(stage2, number_of_positions[2], direction, operation, operand[7]);
    out_data_d = (operation == OP_STORE) ? in_data : stage4;
  end

  // Output register: the only storage in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_data_q <= 8'h00;
    else     out_data_q <= out_data_d;
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_three_function_barrel_shifter.sv
// Scoreboard bench for three_function_barrel_shifter using hand-computed directed vectors.
module tb_three_function_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [1:0] operation;
  logic [2:0] number_of_positions;
  logic       direction;
  logic [7:0] out_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  three_function_barrel_shifter dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_data             (in_data),
    .operation           (operation),
    .number_of_positions (number_of_positions),
    .direction           (direction),
    .out_data            (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] op, input logic [2:0] n,
                       input logic dir, input logic [7:0] exp, input string name);
    @(negedge clk);
    in_data             = d;
    operation           = op;
    number_of_positions = n;
    direction           = dir;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // Monitor: the output register presents a new result after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(name_q.pop_front(), out_data, exp_q.pop_front());
  end

  initial begin
    rst                 = 1'b1;
    in_data             = 8'h5A;
    operation           = 2'd0;
    number_of_positions = 3'd0;
    direction           = 1'b0;
    repeat (2) @(posedge clk);
    #2 check("reset_state", out_data, 8'h00);
    @(negedge clk) rst = 1'b0;

    drive(8'hDA, 2'd1, 3'd2, 1'b1, 8'hB6, "rot_r2_DA");
    drive(8'hDA, 2'd3, 3'd2, 1'b1, 8'hF6, "ash_r2_DA");
    drive(8'hDA, 2'd1, 3'd3, 1'b0, 8'hD6, "rot_l3_DA");
    drive(8'hDA, 2'd2, 3'd2, 1'b0, 8'h68, "lsh_l2_DA");
    drive(8'hFF, 2'd1, 3'd2, 1'b1, 8'hFF, "rot_r2_FF");
    drive(8'hAA, 2'd0, 3'd0, 1'b0, 8'hAA, "store_AA");
    drive(8'h3C, 2'd0, 3'd5, 1'b1, 8'h3C, "store_ignores_n");
    drive(8'h81, 2'd1, 3'd7, 1'b0, 8'hC0, "rot_l7_81");
    drive(8'h01, 2'd1, 3'd7, 1'b1, 8'h02, "rot_r7_01");
    drive(8'h03, 2'd2, 3'd7, 1'b0, 8'h80, "lsh_l7_03");
    drive(8'h81, 2'd3, 3'd3, 1'b0, 8'h08, "ash_l3_zero_fill");
    drive(8'hDA, 2'd2, 3'd4, 1'b1, 8'h0D, "lsh_r4_DA");
    drive(8'hDA, 2'd3, 3'd3, 1'b1, 8'hFB, "ash_r3_neg");
    drive(8'h5A, 2'd3, 3'd1, 1'b1, 8'h2D, "ash_r1_pos");
    for (int op = 0; op < 4; op++) begin
      drive(8'h5C, op[1:0], 3'd0, 1'b0, 8'h5C, $sformatf("n0_op%0d_left", op));
      drive(8'hC5, op[1:0], 3'd0, 1'b1, 8'hC5, $sformatf("n0_op%0d_right", op));
    end
    drive(8'hAA, 2'd0, 3'd0, 1'b0, 8'hAA, "pre_reset_store");

    // Asynchronous reset mid-run, between clock edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset_immediate", out_data, 8'h00);
    @(posedge clk);
    #2 check("reset_holds_over_edge", out_data, 8'h00);
    @(negedge clk) rst = 1'b0;

    drive(8'h80, 2'd3, 3'd7, 1'b1, 8'hFF, "ash_r7_80");
    drive(8'h80, 2'd2, 3'd7, 1'b1, 8'h01, "lsh_r7_80");
    drive(8'h80, 2'd1, 3'd7, 1'b1, 8'h01, "rot_r7_80");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
